// File: rtl/defuse_sweep_ctrl.sv
// defuse_sweep_ctrl: reveal sequencer for one click on the minefield.
// Probes the clicked cell, then walks its row left and right, issuing one
// registered write strobe per defused cell.
// Build option: define DEFUSE_VERTICAL_SWEEP_EN to follow the row walk with
// an up/down walk along the clicked column (port list unchanged).
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a valid click
// S_CHECK   | probe clicked cell; mine ends the sweep with hit_mine
// S_SWEEP_L | walk row leftwards from x0-1 until a mine or column 0
// S_SWEEP_R | walk row rightwards from x0+1 until a mine or column N-1
// S_SWEEP_U | (vertical build) walk column upwards from y0-1
// S_SWEEP_D | (vertical build) walk column downwards from y0+1
// S_DONE    | one-cycle done pulse, then back to idle
module defuse_sweep_ctrl #(
    parameter int MAX_N = 16,
    parameter int CNT_W = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                level,
    input  logic                      new_game,
    input  logic                      click_req,
    input  logic [$clog2(MAX_N):0]    click_x,
    input  logic [$clog2(MAX_N):0]    click_y,
    output logic [$clog2(MAX_N):0]    mine_rd_x,
    output logic [$clog2(MAX_N):0]    mine_rd_y,
    input  logic                      mine_bit,
    output logic                      wr_en,
    output logic [$clog2(MAX_N):0]    wr_x,
    output logic [$clog2(MAX_N):0]    wr_y,
    output logic                      busy,
    output logic                      done,
    output logic                      hit_mine,
    output logic [CNT_W-1:0]          cells_defused
);
    localparam int CW = $clog2(MAX_N) + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SWEEP_L, S_SWEEP_R, S_SWEEP_U, S_SWEEP_D, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   x0_q, x0_d, y0_q, y0_d, cur_q, cur_d;
    logic [1:0]      lvl_q, lvl_d;
    logic            hit_q, hit_d;
    logic            wr_en_q;
    logic [CW-1:0]   wr_x_q, wr_y_q;
    logic [CNT_W-1:0] cnt_q;

    logic            sch_en;
    logic [CW-1:0]   sch_x, sch_y;
    logic [CW-1:0]   n_cur, nm1, n_req;
    logic            abort;
    state_t          hend_state;
    logic [CW-1:0]   hend_cur;

    function automatic logic [CW-1:0] n_of(input logic [1:0] lvl);
        case (lvl)
            2'd1:    n_of = CW'(8);
            2'd2:    n_of = CW'(10);
            2'd3:    n_of = CW'(16);
            default: n_of = '0;
        endcase
    endfunction

    // Board size follows the level latched at acceptance; a level change mid-sweep aborts.
    assign n_cur = n_of(lvl_q);
    assign nm1   = n_cur - ONE;
    assign n_req = n_of(level);
    assign abort = (state_q != S_IDLE) && (new_game || (level != lvl_q));

`ifdef DEFUSE_VERTICAL_SWEEP_EN
    // End of the row walk hands over to the column walk, skipping up when already at row 0.
    always_comb begin
        if (y0_q == '0) begin
            hend_state = S_SWEEP_D;
            hend_cur   = y0_q + ONE;
        end else begin
            hend_state = S_SWEEP_U;
            hend_cur   = y0_q - ONE;
        end
    end
`else
    // End of the row walk finishes the sweep.
    assign hend_state = S_DONE;
    assign hend_cur   = cur_q;
`endif

    // Next-state, probe address, write scheduling and done/hit pulses.
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        cur_d     = cur_q;
        lvl_d     = lvl_q;
        hit_d     = hit_q;
        sch_en    = 1'b0;
        sch_x     = '0;
        sch_y     = '0;
        mine_rd_x = '0;
        mine_rd_y = '0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                hit_d = 1'b0;
                if (click_req && (level != 2'd0) &&
                    (click_x != '0) && (click_x <= n_req) &&
                    (click_y != '0) && (click_y <= n_req)) begin
                    x0_d    = click_x - ONE;
                    y0_d    = click_y - ONE;
                    lvl_d   = level;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                mine_rd_x = x0_q;
                mine_rd_y = y0_q;
                if (mine_bit) begin
                    hit_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    sch_en = 1'b1;
                    sch_x  = x0_q;
                    sch_y  = y0_q;
                    if (x0_q == '0) begin
                        cur_d   = x0_q + ONE;
                        state_d = S_SWEEP_R;
                    end else begin
                        cur_d   = x0_q - ONE;
                        state_d = S_SWEEP_L;
                    end
                end
            end
            S_SWEEP_L: begin
                mine_rd_x = cur_q;
                mine_rd_y = y0_q;
                if (mine_bit) begin
                    cur_d   = x0_q + ONE;
                    state_d = S_SWEEP_R;
                end else begin
                    sch_en = 1'b1;
                    sch_x  = cur_q;
                    sch_y  = y0_q;
                    if (cur_q == '0) begin
                        cur_d   = x0_q + ONE;
                        state_d = S_SWEEP_R;
                    end else begin
                        cur_d = cur_q - ONE;
                    end
                end
            end
            S_SWEEP_R: begin
                // Clicked at the right edge: nothing to the right, no probe.
                if (cur_q > nm1) begin
                    state_d = hend_state;
                    cur_d   = hend_cur;
                end else begin
                    mine_rd_x = cur_q;
                    mine_rd_y = y0_q;
                    if (mine_bit) begin
                        state_d = hend_state;
                        cur_d   = hend_cur;
                    end else begin
                        sch_en = 1'b1;
                        sch_x  = cur_q;
                        sch_y  = y0_q;
                        if (cur_q == nm1) begin
                            state_d = hend_state;
                            cur_d   = hend_cur;
                        end else begin
                            cur_d = cur_q + ONE;
                        end
                    end
                end
            end
`ifdef DEFUSE_VERTICAL_SWEEP_EN
            S_SWEEP_U: begin
                mine_rd_x = x0_q;
                mine_rd_y = cur_q;
                if (mine_bit) begin
                    cur_d   = y0_q + ONE;
                    state_d = S_SWEEP_D;
                end else begin
                    sch_en = 1'b1;
                    sch_x  = x0_q;
                    sch_y  = cur_q;
                    if (cur_q == '0) begin
                        cur_d   = y0_q + ONE;
                        state_d = S_SWEEP_D;
                    end else begin
                        cur_d = cur_q - ONE;
                    end
                end
            end
            S_SWEEP_D: begin
                if (cur_q > nm1) begin
                    state_d = S_DONE;
                end else begin
                    mine_rd_x = x0_q;
                    mine_rd_y = cur_q;
                    if (mine_bit) begin
                        state_d = S_DONE;
                    end else begin
                        sch_en = 1'b1;
                        sch_x  = x0_q;
                        sch_y  = cur_q;
                        if (cur_q == nm1) state_d = S_DONE;
                        else              cur_d   = cur_q + ONE;
                    end
                end
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort drops the sweep silently; a write already registered still goes out.
        if (abort) begin
            state_d = S_IDLE;
            sch_en  = 1'b0;
            sch_x   = '0;
            sch_y   = '0;
            done    = 1'b0;
        end
    end

    assign hit_mine      = done & hit_q;
    assign busy          = (state_q != S_IDLE);
    assign wr_en         = wr_en_q;
    assign wr_x          = wr_x_q;
    assign wr_y          = wr_y_q;
    assign cells_defused = cnt_q;

    // State, latched click context and one-cycle-delayed write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            cur_q   <= '0;
            lvl_q   <= 2'd0;
            hit_q   <= 1'b0;
            wr_en_q <= 1'b0;
            wr_x_q  <= '0;
            wr_y_q  <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            cur_q   <= cur_d;
            lvl_q   <= lvl_d;
            hit_q   <= hit_d;
            wr_en_q <= sch_en;
            wr_x_q  <= sch_x;
            wr_y_q  <= sch_y;
        end
    end

    // Saturating count of issued writes; new_game clears and wins over an increment.
    always_ff @(posedge clk) begin
        if (rst || new_game)               cnt_q <= '0;
        else if (wr_en_q && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
endmodule

// File: tb/tb_defuse_sweep_ctrl.sv
// Self-checking bench for defuse_sweep_ctrl (default build, row sweep only).
module tb_defuse_sweep_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] level;
    logic       new_game, click_req, mine_bit;
    logic [4:0] click_x, click_y, mine_rd_x, mine_rd_y, wr_x, wr_y;
    logic       wr_en, busy, done, hit_mine;
    logic [8:0] cells_defused;

    defuse_sweep_ctrl #(.MAX_N(16), .CNT_W(9)) dut (
        .clk(clk), .rst(rst), .level(level), .new_game(new_game),
        .click_req(click_req), .click_x(click_x), .click_y(click_y),
        .mine_rd_x(mine_rd_x), .mine_rd_y(mine_rd_y), .mine_bit(mine_bit),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .busy(busy), .done(done),
        .hit_mine(hit_mine), .cells_defused(cells_defused)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit mine_map [16][16];
    always_comb begin
        mine_bit = 1'b0;
        if (!mine_rd_x[4] && !mine_rd_y[4]) mine_bit = mine_map[mine_rd_y[3:0]][mine_rd_x[3:0]];
    end

    typedef struct { int x; int y; } wr_t;
    typedef struct { int c; int hit; } dn_t;
    wr_t wq[$];
    dn_t dq[$];
    wr_t mw;
    dn_t md;
    int errors = 0, checks = 0, model_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int n_of(input int lvl);
        return (lvl == 1) ? 8 : (lvl == 2) ? 10 : (lvl == 3) ? 16 : 0;
    endfunction

    function automatic void push_wr(input int x, input int y);
        wr_t w;
        w.x = x; w.y = y;
        wq.push_back(w);
        if (model_cnt < 511) model_cnt++;
    endfunction

    // Reference: reveal the clicked cell, then extend left and right until a mine or the edge.
    function automatic void model_click(input int lvl, input int cx, input int cy, input int acc);
        int n, x0, y0, lp, rc;
        dn_t d;
        n = n_of(lvl);
        if (n == 0 || cx < 1 || cx > n || cy < 1 || cy > n) return;
        x0 = cx - 1; y0 = cy - 1;
        if (mine_map[y0][x0]) begin
            d.c = acc + 2; d.hit = 1;
            dq.push_back(d);
            return;
        end
        push_wr(x0, y0);
        lp = 0;
        for (int x = x0 - 1; x >= 0; x--) begin
            lp++;
            if (mine_map[y0][x]) break;
            push_wr(x, y0);
        end
        rc = 0;
        if (x0 + 1 > n - 1) rc = 1;
        for (int x = x0 + 1; x <= n - 1; x++) begin
            rc++;
            if (mine_map[y0][x]) break;
            push_wr(x, y0);
        end
        d.c = acc + 1 + lp + rc + 1; d.hit = 0;
        dq.push_back(d);
    endfunction

    // Monitor: pop and compare whenever the DUT presents a write or a done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (wq.size() == 0) chk("wr_unexpected", int'(wr_en), 0);
                else begin
                    mw = wq.pop_front();
                    chk("wr_x", int'(wr_x), mw.x);
                    chk("wr_y", int'(wr_y), mw.y);
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("done_unexpected", int'(done), 0);
                else begin
                    md = dq.pop_front();
                    chk("done_cycle", cyc, md.c);
                    chk("hit_mine", int'(hit_mine), md.hit);
                end
            end else if (hit_mine) begin
                chk("hit_without_done", int'(hit_mine), 0);
            end
        end
    end

    task automatic clear_map();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) mine_map[y][x] = 1'b0;
    endtask

    task automatic set_level(input int lvl);
        @(posedge clk); #1;
        level = 2'(lvl);
    endtask

    task automatic click(input int cx, input int cy, input bit model);
        @(posedge clk); #1;
        click_req = 1'b1;
        click_x   = 5'(cx);
        click_y   = 5'(cy);
        if (model) model_click(int'(level), cx, cy, cyc);
        @(posedge clk); #1;
        click_req = 1'b0;
        click_x   = '0;
        click_y   = '0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 60; i++) begin
            if (wq.size() == 0 && dq.size() == 0) break;
            @(negedge clk);
        end
        if (i == 60) begin
            chk({name, "_timeout"}, wq.size() + dq.size(), 0);
            wq.delete();
            dq.delete();
        end
        repeat (2) @(negedge clk);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_count"}, int'(cells_defused), model_cnt);
    endtask

    task automatic pulse_new_game();
        @(posedge clk); #1;
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        chk("new_game_count", int'(cells_defused), 0);
    endtask

    initial begin
        int lvl, n, cx, cy;
        wr_t w;
        rst = 1'b1; level = 2'd0; new_game = 1'b0; click_req = 1'b0;
        click_x = '0; click_y = '0;
        clear_map();
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_count", int'(cells_defused), 0);
        chk("rst_rd_x", int'(mine_rd_x), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Easy board, no mines, interior click.
        set_level(1);
        click(4, 3, 1);
        wait_idle("easy_clear");

        // Hard board, row mines on both sides of the click.
        pulse_new_game();
        set_level(3);
        mine_map[5][1] = 1'b1; mine_map[5][12] = 1'b1;
        click(6, 6, 1);
        wait_idle("hard_mines");

        // Medium board, mine on the clicked cell.
        clear_map();
        set_level(2);
        mine_map[0][0] = 1'b1;
        click(1, 1, 1);
        wait_idle("medium_hit");

        // Right edge click, out-of-range click, level 0.
        clear_map();
        set_level(1);
        click(8, 1, 1);
        wait_idle("easy_edge");
        click(9, 1, 1);
        wait_idle("easy_oob");
        click(3, 0, 1);
        wait_idle("easy_zero");
        set_level(0);
        click(2, 2, 1);
        wait_idle("level0");

        // Second click while busy must be ignored.
        set_level(2);
        click(5, 5, 1);
        repeat (2) @(posedge clk);
        click(2, 2, 0);
        wait_idle("busy_click");

        // Level change at cycle 4 of a hard sweep: three writes out, no done.
        set_level(3);
        @(posedge clk); #1;
        click_req = 1'b1; click_x = 5'd8; click_y = 5'd8;
        for (int k = 0; k < 3; k++) begin
            w.x = 7 - k; w.y = 7;
            wq.push_back(w);
            model_cnt++;
        end
        @(posedge clk); #1;
        click_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 level = 2'd1;
        @(negedge clk);
        chk("abort_busy_hold", int'(busy), 1);
        @(negedge clk);
        chk("abort_busy_drop", int'(busy), 0);
        wait_idle("abort_level");

        // new_game mid-sweep aborts and clears the count.
        @(posedge clk); #1;
        click_req = 1'b1; click_x = 5'd5; click_y = 5'd2;
        w.x = 4; w.y = 1; wq.push_back(w);
        w.x = 3; w.y = 1; wq.push_back(w);
        @(posedge clk); #1;
        click_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        chk("newgame_abort_busy", int'(busy), 0);
        wait_idle("abort_newgame");

        // Randomised clicks on random mine maps.
        for (int t = 0; t < 30; t++) begin
            clear_map();
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    mine_map[y][x] = ($urandom_range(0, 5) == 0);
            lvl = $urandom_range(1, 3);
            n = n_of(lvl);
            cx = $urandom_range(1, n);
            cy = $urandom_range(1, n);
            if ($urandom_range(0, 7) == 0) cx = ($urandom_range(0, 1) == 0) ? 0 : n + 1;
            set_level(lvl);
            click(cx, cy, 1);
            wait_idle("random");
            if (t % 6 == 5) pulse_new_game();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
